ex_forward_ctrl: RTL and testbench

EX-stage operand forwarding and load-use hazard controller for the 5-stage pipelined datapath. It tracks the destination registers of the instructions in EX, MEM and WB in its own shadow pipeline. It drives registered 2-bit selects into the two 32-bit 3-to-1 ALU-operand muxes, and raises a one-cycle stall when a load result is needed one instruction too early. It sits between decode and the EX operand muxes.

---
 rtl/ex_forward_ctrl.sv | 119 +++++++++++
 tb/tb_ex_forward_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_forward_ctrl.sv
// EX-stage operand forwarding and load-use hazard controller with an EX/MEM/WB shadow pipeline.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module ex_forward_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [4:0]  id_dest,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        flush,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        stall,
  output logic [31:0] stall_count,
  output logic [31:0] fwd_count,
  output logic [23:0] shadow_state
);

  // Handshake: decode presents an instruction with id_valid; it is accepted into EX
  // on an edge where stall and flush are both low, otherwise EX receives a bubble.

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic [4:0] dest;
  } stage_t;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_EX  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;

  stage_t     ex_q, mem_q, wb_q;
  stage_t     ex_d;
  logic       raw;
  logic       advance;
  logic [1:0] sel_a_d, sel_b_d;

  function automatic logic stage_hits(input stage_t s, input logic [4:0] r);
    return s.valid && s.reg_write && (s.dest == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] pick_sel(input stage_t ex_s, input stage_t mem_s,
                                          input logic [4:0] r, input logic uses);
    logic [1:0] sel;
    sel = SEL_RF;
    if (uses && stage_hits(ex_s, r))       sel = SEL_EX;
    else if (uses && stage_hits(mem_s, r)) sel = SEL_MEM;
    return sel;
  endfunction

  always_comb begin
    raw = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.dest != 5'd0) &&
          ((id_uses_rs && (ex_q.dest == id_rs)) || (id_uses_rt && (ex_q.dest == id_rt)));
    // A squashed instruction never waits on a load.
    stall   = raw && !flush;
    advance = id_valid && !stall && !flush;
  end

  always_comb begin
    ex_d    = '0;
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (advance) begin
      ex_d.valid     = 1'b1;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      ex_d.dest      = id_dest;
      sel_a_d        = pick_sel(ex_q, mem_q, id_rs, id_uses_rs);
      sel_b_d        = pick_sel(ex_q, mem_q, id_rt, id_uses_rt);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      fwd_a_sel <= SEL_RF;
      fwd_b_sel <= SEL_RF;
    end else begin
      wb_q      <= mem_q;
      mem_q     <= ex_q;
      ex_q      <= ex_d;
      fwd_a_sel <= sel_a_d;
      fwd_b_sel <= sel_b_d;
    end
  end

  assign shadow_state = {wb_q, mem_q, ex_q};

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] fwd_inc;

  always_comb begin
    fwd_inc = 32'd0;
    if (sel_a_d != SEL_RF) fwd_inc = fwd_inc + 32'd1;
    if (sel_b_d != SEL_RF) fwd_inc = fwd_inc + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= 32'd0;
      fwd_count   <= 32'd0;
    end else begin
      if (stall) stall_count <= stall_count + 32'd1;
      fwd_count <= fwd_count + fwd_inc;
    end
  end
`else
  assign stall_count = 32'd0;
  assign fwd_count   = 32'd0;
`endif

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Directed bench for ex_forward_ctrl: forwarding selects, load-use stall, $0 rule, flush, reset.
// Counter expectations follow HAZ_PERF_CNT_EN as defined for the build.
module tb_ex_forward_ctrl;
  logic        clk;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall;
  logic [31:0] stall_count, fwd_count;
  logic [23:0] shadow_state;

  int n_vec;
  int n_err;
  logic [31:0] exp_stalls;
  logic [31:0] exp_fwds;

  ex_forward_ctrl dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
    .stall_count(stall_count), .fwd_count(fwd_count), .shadow_state(shadow_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dest,
                       input logic rw, input logic mr, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dest = dest; id_reg_write = rw; id_mem_read = mr; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sels(input string tag, input logic [1:0] a, input logic [1:0] b);
    chk({tag, "_a"}, {30'd0, fwd_a_sel}, {30'd0, a});
    chk({tag, "_b"}, {30'd0, fwd_b_sel}, {30'd0, b});
  endtask

  task automatic chk_counters(input string tag);
`ifdef HAZ_PERF_CNT_EN
    chk({tag, "_stall_cnt"}, stall_count, exp_stalls);
    chk({tag, "_fwd_cnt"}, fwd_count, exp_fwds);
`else
    chk({tag, "_stall_cnt"}, stall_count, 32'd0);
    chk({tag, "_fwd_cnt"}, fwd_count, 32'd0);
`endif
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_stalls = 0; exp_fwds = 0;
    reset_n = 1'b0;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk_sels("reset", 2'd0, 2'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk_counters("reset");
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // ALU-ALU: add $3, then sub reading rs=$3
    issue(1, 5'd1, 5'd2, 0, 0, 5'd3, 1, 0, 0);
    step();
    chk_sels("alu_prod", 2'd0, 2'd0);
    issue(1, 5'd3, 5'd4, 1, 1, 5'd6, 1, 0, 0);
    #1 chk("alu_stall", {31'd0, stall}, 32'd0);
    step();
    chk_sels("alu_alu", 2'd1, 2'd0);
    exp_fwds += 1;

    // Distance-2: producer of $5 in MEM
    issue(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 0, 0);
    step();
    issue(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    step();
    issue(1, 5'd1, 5'd5, 0, 1, 5'd7, 1, 0, 0);
    step();
    chk_sels("dist2", 2'd0, 2'd2);
    exp_fwds += 1;

    // Two producers of $5: EX/MEM wins over MEM/WB
    issue(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 0, 0);
    step();
    issue(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 0, 0);
    step();
    issue(1, 5'd1, 5'd5, 0, 1, 5'd7, 1, 0, 0);
    step();
    chk_sels("newer_wins", 2'd0, 2'd1);
    exp_fwds += 1;

    // Load-use: lw $8 then consumer of $8
    issue(1, 5'd0, 5'd0, 0, 0, 5'd8, 1, 1, 0);
    step();
    issue(1, 5'd8, 5'd2, 1, 1, 5'd9, 1, 0, 0);
    #1 chk("lu_stall_on", {31'd0, stall}, 32'd1);
    step();
    exp_stalls += 1;
    chk_sels("lu_bubble", 2'd0, 2'd0);
    chk("lu_stall_off", {31'd0, stall}, 32'd0);
    step();
    chk_sels("lu_consume", 2'd2, 2'd0);
    exp_fwds += 1;
    chk_counters("lu");

    // $0 rule: load to $0, consumer reads $0
    issue(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0);
    step();
    issue(1, 5'd0, 5'd0, 1, 1, 5'd9, 1, 0, 0);
    #1 chk("zero_ld_stall", {31'd0, stall}, 32'd0);
    step();
    chk_sels("zero_ld", 2'd0, 2'd0);
    issue(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0);
    step();
    issue(1, 5'd0, 5'd0, 1, 1, 5'd9, 1, 0, 0);
    step();
    chk_sels("zero_alu", 2'd0, 2'd0);

    // Flush beats stall; squashed slot (dest $8) never forwards
    issue(1, 5'd0, 5'd0, 0, 0, 5'd8, 1, 1, 0);
    step();
    issue(1, 5'd8, 5'd0, 1, 0, 5'd8, 1, 0, 1);
    #1 chk("flush_stall", {31'd0, stall}, 32'd0);
    step();
    chk_sels("flush_bubble", 2'd0, 2'd0);
    issue(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    step();
    issue(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0);
    #1 chk("flush_after_stall", {31'd0, stall}, 32'd0);
    step();
    chk_sels("flush_after", 2'd0, 2'd0);

    // Back-to-back loads to $8, each with an immediate consumer
    issue(1, 5'd0, 5'd0, 0, 0, 5'd8, 1, 1, 0);
    step();
    issue(1, 5'd8, 5'd0, 1, 0, 5'd8, 1, 1, 0);
    #1 chk("b2b_stall1", {31'd0, stall}, 32'd1);
    step();
    exp_stalls += 1;
    chk_sels("b2b_bubble1", 2'd0, 2'd0);
    step();
    chk_sels("b2b_ld2", 2'd2, 2'd0);
    exp_fwds += 1;
    issue(1, 5'd8, 5'd0, 1, 0, 5'd9, 1, 0, 0);
    #1 chk("b2b_stall2", {31'd0, stall}, 32'd1);
    step();
    exp_stalls += 1;
    chk_sels("b2b_bubble2", 2'd0, 2'd0);
    step();
    chk_sels("b2b_consume", 2'd2, 2'd0);
    exp_fwds += 1;

    // Reset mid-stream: $10 in WB, $11 in MEM, lw $12 in EX, consumer of $12 stalling
    issue(1, 5'd0, 5'd0, 0, 0, 5'd10, 1, 0, 0);
    step();
    issue(1, 5'd0, 5'd0, 0, 0, 5'd11, 1, 0, 0);
    step();
    issue(1, 5'd11, 5'd0, 1, 0, 5'd12, 1, 1, 0);
    step();
    chk_sels("rst_pre", 2'd1, 2'd0);
    exp_fwds += 1;
    issue(1, 5'd12, 5'd11, 1, 1, 5'd13, 1, 0, 0);
    #1 chk("rst_pre_stall", {31'd0, stall}, 32'd1);
    chk_counters("rst_pre");
    reset_n = 1'b0;
    #1;
    exp_stalls = 0; exp_fwds = 0;
    chk_sels("rst_mid", 2'd0, 2'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk_counters("rst_mid");
    step();
    chk_sels("rst_hold", 2'd0, 2'd0);
    reset_n = 1'b1;
    issue(1, 5'd12, 5'd11, 1, 1, 5'd13, 1, 0, 0);
    #1 chk("rst_post_stall", {31'd0, stall}, 32'd0);
    step();
    chk_sels("rst_post", 2'd0, 2'd0);
    issue(1, 5'd10, 5'd0, 1, 0, 5'd14, 1, 0, 0);
    step();
    chk_sels("rst_post2", 2'd0, 2'd0);
    chk_counters("rst_post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
